uart_frame_scheduler: RTL
=========================

Name: uart_frame_scheduler

Overview:
Sequences one inverter switching step across the NUM_MODULES module UARTs.
- Collects per-module transistor codes delivered by the SPI request block as (uart_id, sin_index) words.
- On commit, launches all loaded UART transmitters in the same cycle and waits for every launched transmitter to go idle.
- Then emits the global shoot pulse.
- Sits between SPI_request_data and the uart_tx array in the top-level NORMAL_MODE path, replacing ad-hoc sequencing in the top FSM.

Parameters:
- NUM_MODULES, 9, number of module UARTs (slot ids 1..NUM_MODULES).
- COMMIT_ID, 15, uart_id value that means commit the frame.
- SETTLE_CYCLES, 2, cycles after start_tx before tx_busy is sampled.
- TIMEOUT_CYCLES, 24000, max cycles waiting for all tx_busy low (1 ms at 24 MHz).
- SHOOT_CYCLES, 24, shoot pulse width in clk cycles.
- GUARD_CYCLES, 48, dead time after shoot before the next frame is accepted.

Ports:
- clk  in  1  system clock (24 MHz HFOSC/2).
- reset  in  1  synchronous, active-high reset.
- enable  in  1  scheduler enabled (top drives it high in NORMAL_MODE).
- data_valid  in  1  one-cycle strobe from the SPI block.
- uart_id  in  4  target slot, or COMMIT_ID.
- sin_index  in  12  payload: [7:0] transistor code, [11:8] must be 0.
- start_tx  out  NUM_MODULES  per-UART one-cycle start strobe (bit k = slot k+1).
- data_to_tx  out  8*NUM_MODULES  per-UART byte; slot k+1 at [8k+7:8k].
- tx_busy  in  NUM_MODULES  per-UART busy.
- shoot  out  1  shoot pulse to all modules.
- busy  out  1  high in any state other than COLLECT.
- err_bad_id  out  1  one-cycle pulse: bad uart_id or nonzero payload[11:8].
- err_timeout  out  1  one-cycle pulse: WAIT_DONE timed out.
- err_overrun  out  1  sticky; set when data_valid arrives while busy, cleared only by reset.

Behaviour:
- Reset: all outputs 0; state COLLECT; loaded_mask 0; slot bytes 0; counters 0. Reset mid-frame aborts immediately, with no shoot and no start_tx; the UARTs share the same reset.
- enable low: state is forced to COLLECT next cycle, mask is cleared, data_valid is ignored and no errors are flagged. An in-flight transmission is not recalled and shoot is suppressed.
- COLLECT, data_valid with uart_id in 1..NUM_MODULES and payload[11:8]==0:
  - slot byte <= payload[7:0];
  - mask bit set;
  - a rewrite of an already-loaded slot overwrites it silently (last write wins).
- COLLECT, data_valid with uart_id == COMMIT_ID:
  - if mask != 0, go to DISPATCH;
  - if mask == 0, ignore (no error).
- COLLECT, any other uart_id or bad payload: slot unchanged, err_bad_id pulses the next cycle.
- Auto-commit: when the cycle's write makes the mask all-ones, go to DISPATCH without waiting for COMMIT_ID. A COMMIT_ID arriving later in COLLECT with an empty mask is ignored.
- DISPATCH (1 cycle): start_tx = mask for exactly this cycle. data_to_tx is registered and stable from the cycle the slot is written until the state leaves WAIT_DONE. Go to SETTLE.
  - Latency: the commit strobe at cycle N gives start_tx high at cycle N+1.
- SETTLE: count SETTLE_CYCLES, then go to WAIT_DONE.
- WAIT_DONE:
  - if (tx_busy & mask) == 0, go to SHOOT;
  - else, after TIMEOUT_CYCLES in this state, pulse err_timeout, clear the mask and go to COLLECT, skipping shoot.
- SHOOT: shoot high for exactly SHOOT_CYCLES cycles, then go to GUARD.
- GUARD: count GUARD_CYCLES, then clear the mask and go to COLLECT.
- busy = (state != COLLECT), registered.
- data_valid with busy high: word dropped, err_overrun set. data_valid on the same cycle busy falls is accepted, because COLLECT is already the registered state.
- Counters: one shared down-counter of width clog2(max(TIMEOUT_CYCLES, GUARD_CYCLES, SHOOT_CYCLES)+1), reloaded on each state entry. Counting saturates, with no wrap.

Decomposition:
- Shared package/header: state encodings (COLLECT, DISPATCH, SETTLE, WAIT_DONE, SHOOT, GUARD), COMMIT_ID, and default timing constants derived from the existing clock config defines.
- One sub-module is natural: frame_slot_bank, holding the per-slot byte registers, loaded_mask, and id/payload validation with decode.
- The FSM and counter stay in uart_frame_scheduler.

Test Plan:
- Write ids 1..9 with codes 0x11..0x99, tx_busy held high 100 cycles → auto-commit: start_tx=9'h1FF for one cycle one cycle after the 9th strobe, data_to_tx slot1=0x11 … slot9=0x99, shoot high 24 cycles after busy falls, busy low after GUARD.
- Write id 3=0xA5, then id 15 → start_tx=9'h004 only; shoot follows once tx_busy[2] drops; other tx_busy bits are ignored.
- id 0, id 12, and id 2 with sin_index=12'h1FF → err_bad_id pulses three times; mask stays 0; id 15 afterwards causes no dispatch.
- tx_busy[4] stuck high after dispatch → err_timeout pulses exactly 24000+SETTLE cycles after DISPATCH; shoot never asserts; state returns to COLLECT.
- data_valid during SHOOT → err_overrun set and held; word not stored; the next frame works normally.
- Assert reset during SHOOT → next cycle shoot=0, busy=0, start_tx=0, errors=0; enable low during WAIT_DONE → COLLECT, no shoot.

Source files
------------

// File: rtl/uart_frame_scheduler_pkg.sv
// Shared definitions for the UART frame scheduler: state encodings,
// the commit id and default timing derived from the 24 MHz system clock.
package uart_frame_scheduler_pkg;

  // System clock after the HFOSC/2 divider.
  localparam int CLK_HZ = 24_000_000;

  localparam int NUM_MODULES_DEFAULT    = 9;
  localparam int COMMIT_ID_DEFAULT      = 15;
  localparam int SETTLE_CYCLES_DEFAULT  = 2;
  // 1 ms budget for every launched transmitter to finish its byte.
  localparam int TIMEOUT_CYCLES_DEFAULT = CLK_HZ / 1000;
  // 1 us shoot pulse.
  localparam int SHOOT_CYCLES_DEFAULT   = CLK_HZ / 1_000_000;
  // 2 us dead time before the next frame is accepted.
  localparam int GUARD_CYCLES_DEFAULT   = 2 * SHOOT_CYCLES_DEFAULT;

  typedef enum logic [2:0] {
    COLLECT   = 3'd0,
    DISPATCH  = 3'd1,
    SETTLE    = 3'd2,
    WAIT_DONE = 3'd3,
    SHOOT     = 3'd4,
    GUARD     = 3'd5
  } sched_state_t;

  // Largest of three cycle counts, used to size the shared down-counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/uart_frame_scheduler_frame_slot_bank.sv
// Per-slot transistor code registers and the loaded-slot mask, plus the
// decode/validation of incoming (uart_id, sin_index) words.
module frame_slot_bank
  import uart_frame_scheduler_pkg::*;
#(
  parameter int NUM_MODULES = NUM_MODULES_DEFAULT,
  parameter int COMMIT_ID   = COMMIT_ID_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write_en,
  input  logic                     clear_mask,
  input  logic [3:0]               uart_id,
  input  logic [11:0]              sin_index,
  output logic [8*NUM_MODULES-1:0] slot_bytes,
  output logic [NUM_MODULES-1:0]   loaded_mask,
  output logic [NUM_MODULES-1:0]   mask_after,
  output logic                     slot_write,
  output logic                     commit_req,
  output logic                     bad_word
);

  logic [NUM_MODULES-1:0] slot_sel;
  logic                   payload_ok;

  // Decode the target slot, classify the word and preview the mask as it
  // would look after this word is stored, so the FSM can auto-commit.
  always_comb begin
    slot_sel = '0;
    for (int k = 0; k < NUM_MODULES; k++) begin
      slot_sel[k] = (uart_id == 4'(k + 1));
    end
    payload_ok = (sin_index[11:8] == 4'h0);
    commit_req = (uart_id == 4'(COMMIT_ID));
    slot_write = (|slot_sel) && payload_ok;
    bad_word   = !commit_req && !slot_write;
    mask_after = slot_write ? (loaded_mask | slot_sel) : loaded_mask;
  end

  // Store the byte of a valid slot word and mark the slot loaded; a slot
  // that is written twice simply keeps the latest byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_bytes  <= '0;
      loaded_mask <= '0;
    end else if (clear_mask) begin
      loaded_mask <= '0;
    end else if (write_en && slot_write) begin
      for (int k = 0; k < NUM_MODULES; k++) begin
        if (slot_sel[k]) begin
          slot_bytes[8*k +: 8] <= sin_index[7:0];
        end
      end
      loaded_mask <= mask_after;
    end
  end

endmodule

// File: rtl/uart_frame_scheduler.sv
// Sequences one inverter switching step: collects per-module codes, launches
// all loaded UARTs together, waits for them to drain, then fires shoot.
module uart_frame_scheduler
  import uart_frame_scheduler_pkg::*;
#(
  parameter int NUM_MODULES    = NUM_MODULES_DEFAULT,
  parameter int COMMIT_ID      = COMMIT_ID_DEFAULT,
  parameter int SETTLE_CYCLES  = SETTLE_CYCLES_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int SHOOT_CYCLES   = SHOOT_CYCLES_DEFAULT,
  parameter int GUARD_CYCLES   = GUARD_CYCLES_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     data_valid,
  input  logic [3:0]               uart_id,
  input  logic [11:0]              sin_index,
  output logic [NUM_MODULES-1:0]   start_tx,
  output logic [8*NUM_MODULES-1:0] data_to_tx,
  input  logic [NUM_MODULES-1:0]   tx_busy,
  output logic                     shoot,
  output logic                     busy,
  output logic                     err_bad_id,
  output logic                     err_timeout,
  output logic                     err_overrun
);

  localparam int CW = $clog2(max3(TIMEOUT_CYCLES, GUARD_CYCLES, SHOOT_CYCLES) + 1);

  // Each load value is "state length minus one" so that a state is left on
  // the cycle its counter reads zero. The settle window is measured from the
  // start_tx strobe, so the DISPATCH cycle itself is part of it.
  localparam logic [CW-1:0] SETTLE_LOAD  = CW'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0);
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] SHOOT_LOAD   = CW'((SHOOT_CYCLES > 0) ? SHOOT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] GUARD_LOAD   = CW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam bit            HAS_SETTLE   = (SETTLE_CYCLES > 1);

  sched_state_t           state;
  logic [CW-1:0]          cnt;
  logic [NUM_MODULES-1:0] loaded_mask;
  logic [NUM_MODULES-1:0] mask_after;
  logic                   slot_write;
  logic                   commit_req;
  logic                   bad_word;
  logic                   write_en;
  logic                   clear_mask;
  logic                   tx_pending;
  logic                   cnt_done;

  // Words are only stored while collecting with the scheduler enabled; the
  // mask empties whenever the FSM heads back to COLLECT.
  always_comb begin
    cnt_done   = (cnt == '0);
    tx_pending = |(tx_busy & loaded_mask);
    write_en   = enable && data_valid && (state == COLLECT);
    clear_mask = !enable
              || ((state == GUARD) && cnt_done)
              || ((state == WAIT_DONE) && tx_pending && cnt_done);
  end

  frame_slot_bank #(
    .NUM_MODULES (NUM_MODULES),
    .COMMIT_ID   (COMMIT_ID)
  ) u_slot_bank (
    .clk         (clk),
    .reset       (reset),
    .write_en    (write_en),
    .clear_mask  (clear_mask),
    .uart_id     (uart_id),
    .sin_index   (sin_index),
    .slot_bytes  (data_to_tx),
    .loaded_mask (loaded_mask),
    .mask_after  (mask_after),
    .slot_write  (slot_write),
    .commit_req  (commit_req),
    .bad_word    (bad_word)
  );

  // Frame sequencer with the shared saturating down-counter; every output
  // is a register updated alongside the state so nothing glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= COLLECT;
      cnt         <= '0;
      start_tx    <= '0;
      shoot       <= 1'b0;
      busy        <= 1'b0;
      err_bad_id  <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else if (!enable) begin
      state       <= COLLECT;
      cnt         <= '0;
      start_tx    <= '0;
      shoot       <= 1'b0;
      busy        <= 1'b0;
      err_bad_id  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      start_tx    <= '0;
      err_bad_id  <= 1'b0;
      err_timeout <= 1'b0;
      if (data_valid && busy) begin
        err_overrun <= 1'b1;
      end
      case (state)
        COLLECT: begin
          if (data_valid) begin
            if (slot_write) begin
              if (&mask_after) begin
                state    <= DISPATCH;
                start_tx <= mask_after;
                busy     <= 1'b1;
              end
            end else if (commit_req) begin
              if (|loaded_mask) begin
                state    <= DISPATCH;
                start_tx <= loaded_mask;
                busy     <= 1'b1;
              end
            end else if (bad_word) begin
              err_bad_id <= 1'b1;
            end
          end
        end
        DISPATCH: begin
          if (HAS_SETTLE) begin
            state <= SETTLE;
            cnt   <= SETTLE_LOAD;
          end else begin
            state <= WAIT_DONE;
            cnt   <= TIMEOUT_LOAD;
          end
        end
        SETTLE: begin
          if (cnt_done) begin
            state <= WAIT_DONE;
            cnt   <= TIMEOUT_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_pending) begin
            state <= SHOOT;
            shoot <= 1'b1;
            cnt   <= SHOOT_LOAD;
          end else if (cnt_done) begin
            state       <= COLLECT;
            busy        <= 1'b0;
            err_timeout <= 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SHOOT: begin
          if (cnt_done) begin
            state <= GUARD;
            shoot <= 1'b0;
            cnt   <= GUARD_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GUARD: begin
          if (cnt_done) begin
            state <= COLLECT;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= COLLECT;
          busy  <= 1'b0;
          shoot <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
